// File: rtl/calc_cmd_sequencer.sv
// Key-event sequencer for calc_top: buffers keypad strobes in a FIFO and replays
// each one on the cmd bus for a fixed hold time followed by a NOP gap.
module calc_cmd_sequencer #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned HOLD_CYCLES  = 10,
  parameter int unsigned GAP_CYCLES   = 2,
  parameter logic [3:0]  NOP_CMD      = 4'b1101,
  parameter logic [3:0]  CLR_CMD      = 4'b1111,
  parameter int unsigned BUSY_TIMEOUT = 255
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     key_valid,
  input  logic [3:0]               key_code,
  input  logic [1:0]               calc_status,
  input  logic                     clear_err,
  output logic [3:0]               cmd_out,
  output logic                     seq_busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               drop_cnt,
  output logic                     timeout_flag
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
  localparam int unsigned WW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_RDY, S_DRIVE, S_GAP} state_t;

  state_t        state, state_d;
  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_d;
  logic [HW-1:0] hold_cnt;
  logic [GW-1:0] gap_cnt;
  logic [WW-1:0] wait_cnt;
  logic [3:0]    cmd_d;

  logic empty_c, full_c, push_req_c, push_ok_c, overflow_c;
  logic rdy_c, err_c, hold_done_c, eval_c;
  logic pop_c, load_c, discard_c, flush_c, wait_inc_c;
  logic [3:0] head_c;
  logic [1:0] drop_inc_c;
  logic [8:0] drop_sum_c;

  assign empty_c     = (count == '0);
  assign full_c      = (count == CW'(DEPTH));
  assign head_c      = mem[rd_ptr];
  assign push_req_c  = key_valid && (key_code != NOP_CMD);
  assign rdy_c       = (calc_status == 2'b00);
  assign err_c       = (calc_status == 2'b10);
  assign hold_done_c = (state == S_DRIVE) && (hold_cnt == HW'(1));

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_d;
  end

  // Next state; IDLE and the last GAP cycle evaluate the head exactly like WAIT_RDY
  always_comb begin
    state_d    = state;
    eval_c     = 1'b0;
    pop_c      = 1'b0;
    load_c     = 1'b0;
    discard_c  = 1'b0;
    flush_c    = 1'b0;
    wait_inc_c = 1'b0;
    case (state)
      S_IDLE:     eval_c = !empty_c;
      S_WAIT_RDY: begin
        if (empty_c) state_d = S_IDLE;
        else         eval_c  = 1'b1;
      end
      S_DRIVE:    if (hold_done_c) state_d = S_GAP;
      S_GAP: begin
        if (gap_cnt == GW'(1)) begin
          if (empty_c) state_d = S_IDLE;
          else         eval_c  = 1'b1;
        end
      end
      default:    state_d = S_IDLE;
    endcase
    if (eval_c) begin
      if (rdy_c || (err_c && (head_c == CLR_CMD))) begin
        pop_c   = 1'b1;
        load_c  = 1'b1;
        state_d = S_DRIVE;
      end else if (err_c) begin
        pop_c     = 1'b1;
        discard_c = 1'b1;
        state_d   = ((count == CW'(1)) && !push_req_c) ? S_IDLE : S_WAIT_RDY;
      end else if (wait_cnt == WW'(BUSY_TIMEOUT - 1)) begin
        flush_c = 1'b1;
        state_d = S_IDLE;
      end else begin
        wait_inc_c = 1'b1;
        state_d    = S_WAIT_RDY;
      end
    end
  end

  // Next cmd_out value
  always_comb begin
    cmd_d = NOP_CMD;
    if (load_c)                                cmd_d = head_c;
    else if ((state == S_DRIVE) && !hold_done_c) cmd_d = cmd_out;
  end

  assign push_ok_c  = push_req_c && (!full_c || pop_c) && !flush_c;
  assign overflow_c = push_req_c && full_c && !pop_c && !flush_c;
  assign count_d    = flush_c ? '0 : (count + CW'(push_ok_c) - CW'(pop_c));
  assign drop_inc_c = 2'(overflow_c) + 2'(discard_c);
  assign drop_sum_c = 9'(drop_cnt) + 9'(drop_inc_c);

  always_ff @(posedge clock) begin
    if (push_ok_c) mem[wr_ptr] <= key_code;
  end

  // FIFO pointers, timers and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      hold_cnt     <= '0;
      gap_cnt      <= '0;
      wait_cnt     <= '0;
      cmd_out      <= NOP_CMD;
      seq_busy     <= 1'b0;
      drop_cnt     <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (flush_c) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok_c) wr_ptr <= wr_ptr + AW'(1);
        if (pop_c)     rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_d;

      if (load_c)                                    hold_cnt <= HW'(HOLD_CYCLES);
      else if ((state == S_DRIVE) && (hold_cnt != '0)) hold_cnt <= hold_cnt - HW'(1);

      if (hold_done_c)                               gap_cnt <= GW'(GAP_CYCLES);
      else if ((state == S_GAP) && (gap_cnt != '0))  gap_cnt <= gap_cnt - GW'(1);

      if (wait_inc_c)                 wait_cnt <= wait_cnt + WW'(1);
      else if (state_d != S_WAIT_RDY) wait_cnt <= '0;

      cmd_out  <= cmd_d;
      seq_busy <= (state_d != S_IDLE) || (count_d != '0);

      if (clear_err)                 drop_cnt <= '0;
      else if (drop_sum_c > 9'd255)  drop_cnt <= 8'hFF;
      else                           drop_cnt <= drop_sum_c[7:0];

      if (clear_err)    timeout_flag <= 1'b0;
      else if (flush_c) timeout_flag <= 1'b1;
    end
  end

  assign fifo_count = count;

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Directed bench for calc_cmd_sequencer with default parameters.
module tb_calc_cmd_sequencer;

  localparam logic [3:0] NOP = 4'b1101;

  logic       clock = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic [1:0] calc_status;
  logic       clear_err;
  logic [3:0] cmd_out;
  logic       seq_busy;
  logic [3:0] fifo_count;
  logic [7:0] drop_cnt;
  logic       timeout_flag;

  int nvec = 0;
  int nerr = 0;

  calc_cmd_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .calc_status  (calc_status),
    .clear_err    (clear_err),
    .cmd_out      (cmd_out),
    .seq_busy     (seq_busy),
    .fifo_count   (fifo_count),
    .drop_cnt     (drop_cnt),
    .timeout_flag (timeout_flag)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_cmd(input string tag, input logic [3:0] code, input int n);
    repeat (n) begin
      tick();
      chk(tag, 32'(cmd_out), 32'(code));
    end
  endtask

  task automatic key(input logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    tick();
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("clear_drop", 32'(drop_cnt), 0);
    chk("clear_tmo", 32'(timeout_flag), 0);
  endtask

  initial begin
    reset = 1'b0; key_valid = 1'b0; key_code = 4'd0; calc_status = 2'b00; clear_err = 1'b0;
    #12;
    chk("rst_cmd", 32'(cmd_out), 32'(NOP));
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    chk("rst_tmo", 32'(timeout_flag), 0);
    chk("rst_busy", 32'(seq_busy), 0);
    tick();
    reset = 1'b1;
    tick();

    // Keys 1,2,3,3 on consecutive cycles, status ready
    key(4'd1);
    chk("t1_lat_nop", 32'(cmd_out), 32'(NOP));
    chk("t1_cnt1", 32'(fifo_count), 1);
    key(4'd2);
    chk("t1_first", 32'(cmd_out), 1);
    key(4'd3);
    key(4'd3);
    key_valid = 1'b0;
    chk("t1_peak", 32'(fifo_count), 3);
    expect_cmd("t1_hold1", 4'd1, 7);
    expect_cmd("t1_gap1", NOP, 2);
    expect_cmd("t1_hold2", 4'd2, 10);
    expect_cmd("t1_gap2", NOP, 2);
    expect_cmd("t1_hold3", 4'd3, 10);
    expect_cmd("t1_gap3", NOP, 2);
    expect_cmd("t1_hold4", 4'd3, 10);
    chk("t1_empty", 32'(fifo_count), 0);
    expect_cmd("t1_gap4", NOP, 2);
    chk("t1_busy_gap", 32'(seq_busy), 1);
    tick();
    chk("t1_busy_end", 32'(seq_busy), 0);

    // Ten keys back to back: one pops immediately, eight fill the FIFO, the tenth drops
    for (int i = 0; i < 10; i++) key(4'(i));
    key_valid = 1'b0;
    chk("t2_drop", 32'(drop_cnt), 1);
    chk("t2_full", 32'(fifo_count), 8);
    expect_cmd("t2_k0", 4'd0, 1);
    expect_cmd("t2_gap", NOP, 2);
    for (int i = 1; i < 9; i++) begin
      expect_cmd("t2_seq", 4'(i), 10);
      expect_cmd("t2_gap", NOP, 2);
    end
    tick();
    chk("t2_idle", 32'(seq_busy), 0);
    chk("t2_drop_hold", 32'(drop_cnt), 1);
    pulse_clear();

    // Busy stall between commands
    key(4'd5);
    key(4'd0);
    key(4'b1011);
    key_valid = 1'b0;
    calc_status = 2'b01;
    expect_cmd("t3_hold5", 4'd5, 8);
    expect_cmd("t3_stall", NOP, 22);
    chk("t3_cnt_stall", 32'(fifo_count), 2);
    calc_status = 2'b00;
    tick();
    chk("t3_resume", 32'(cmd_out), 0);
    chk("t3_tmo", 32'(timeout_flag), 0);
    expect_cmd("t3_hold0", 4'd0, 9);
    expect_cmd("t3_gap", NOP, 2);
    expect_cmd("t3_hold11", 4'b1011, 10);
    expect_cmd("t3_gap", NOP, 2);
    tick();
    chk("t3_idle", 32'(seq_busy), 0);

    // Error status: operands discarded, clear still forwarded
    calc_status = 2'b10;
    key(4'd6);
    key(4'b1100);
    chk("t4_drop1", 32'(drop_cnt), 1);
    key(4'b1111);
    chk("t4_drop2", 32'(drop_cnt), 2);
    key(4'd2);
    key_valid = 1'b0;
    chk("t4_clr", 32'(cmd_out), 32'(4'b1111));
    chk("t4_drop_keep", 32'(drop_cnt), 2);
    chk("t4_cnt", 32'(fifo_count), 1);
    expect_cmd("t4_hold_clr", 4'b1111, 9);
    calc_status = 2'b00;
    expect_cmd("t4_gap", NOP, 2);
    expect_cmd("t4_hold2", 4'd2, 10);
    expect_cmd("t4_gap2", NOP, 2);
    tick();
    chk("t4_idle", 32'(seq_busy), 0);
    pulse_clear();

    // Stuck busy: timeout after 255 waiting cycles flushes the queue
    calc_status = 2'b01;
    key(4'd7);
    key(4'd8);
    key(4'd9);
    key_valid = 1'b0;
    chk("t5_cnt3", 32'(fifo_count), 3);
    repeat (252) tick();
    chk("t5_pre_tmo", 32'(timeout_flag), 0);
    chk("t5_pre_cnt", 32'(fifo_count), 3);
    tick();
    chk("t5_tmo", 32'(timeout_flag), 1);
    chk("t5_flushed", 32'(fifo_count), 0);
    chk("t5_cmd", 32'(cmd_out), 32'(NOP));
    chk("t5_nodrop", 32'(drop_cnt), 0);
    chk("t5_idle", 32'(seq_busy), 0);
    calc_status = 2'b00;
    pulse_clear();

    // Reset during the fourth DRIVE cycle
    key(4'd4);
    key(4'd5);
    key_valid = 1'b0;
    chk("t6_drive", 32'(cmd_out), 4);
    chk("t6_cnt", 32'(fifo_count), 1);
    tick();
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_cmd", 32'(cmd_out), 32'(NOP));
    chk("t6_async_cnt", 32'(fifo_count), 0);
    chk("t6_async_busy", 32'(seq_busy), 0);
    #2;
    reset = 1'b1;
    tick();
    key(4'd3);
    key_valid = 1'b0;
    chk("t6_lat_nop", 32'(cmd_out), 32'(NOP));
    chk("t6_cnt1", 32'(fifo_count), 1);
    tick();
    chk("t6_first", 32'(cmd_out), 3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
